// File: rtl/draw_unit_pkg.sv
// Shared constants and types for the draw unit: VGA timing, frame buffer
// geometry, command word layout and the draw FSM state encoding.
package draw_unit_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Command word A layout; word B is {x0, x1}.
  localparam int CMD_CLEAR_BIT = 15;
  localparam int CMD_COLOR_HI  = 9;
  localparam int CMD_COLOR_LO  = 7;
  localparam int CMD_Y_HI      = 6;

  typedef logic [2:0] pixel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAITB,
    S_LINE,
    S_CLEAR
  } draw_state_t;

  // Returns {min(x0,x1), max(x0,x1)} from a word B.
  function automatic logic [15:0] order_span(input logic [15:0] word_b);
    logic [7:0] a;
    logic [7:0] b;
    a = word_b[15:8];
    b = word_b[7:0];
    return (a <= b) ? {a, b} : {b, a};
  endfunction

endpackage

// File: rtl/draw_unit_if.sv
// CPU command port and VGA output bundle of the draw unit.
interface draw_unit_if;
  import draw_unit_pkg::*;

  logic        we;
  logic [15:0] dataIn;
  logic        full;
  pixel_t      color;
  logic        hsync;
  logic        vsync;

  modport master (output we, dataIn, input full, color, hsync, vsync);
  modport slave  (input we, dataIn, output full, color, hsync, vsync);
endinterface

// File: rtl/draw_unit_sync_fifo.sv
// Generic synchronous FIFO with show-ahead output and a registered full flag.
module draw_unit_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign dout    = mem[rptr];

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (do_pop && !do_push) count_nxt = count - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_COUNT);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/draw_unit_vga_timing.sv
// 640x480@60 timing from a 50 MHz clock: counters step on every second clk.
module draw_unit_vga_timing
  import draw_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       visible,
  output logic       hsync_raw,
  output logic       vsync_raw
);
  logic pix_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  assign visible   = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);
  assign hsync_raw = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
  assign vsync_raw = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
endmodule

// File: rtl/draw_unit.sv
// Command-driven horizontal line rasterizer with a 4x-scaled VGA scan-out of
// a 3-bit frame buffer.
module draw_unit
  import draw_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FB_W       = FB_WIDTH,
  parameter int FB_H       = FB_HEIGHT
) (
  input  logic       clk,
  input  logic       reset,
  draw_unit_if.slave bus
);
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int FB_AW   = $clog2(FB_SIZE);
  localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(FB_SIZE - 1);

  logic [15:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_pop;

  draw_unit_sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (bus.we),
    .din   (bus.dataIn),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (bus.full)
  );

  draw_state_t      state, state_nxt;
  logic             cmd_clear;
  pixel_t           cmd_color;
  logic [6:0]       cmd_y;
  logic [7:0]       x, xe;
  logic [FB_AW-1:0] clr_addr;
  logic [15:0]      span;
  logic             in_range;
  logic [FB_AW-1:0] line_addr;
  logic             fb_we;
  logic [FB_AW-1:0] fb_waddr;
  pixel_t           fb_wdata;

  assign span      = order_span(fifo_dout);
  assign in_range  = (int'(x) < FB_W) && (int'(cmd_y) < FB_H);
  assign line_addr = FB_AW'(int'(cmd_y) * FB_W + int'(x));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!fifo_empty) state_nxt = S_DECODE;
      S_DECODE: state_nxt = cmd_clear ? S_CLEAR : S_WAITB;
      S_WAITB:  if (!fifo_empty) state_nxt = S_LINE;
      S_LINE:   if (x == xe) state_nxt = S_IDLE;
      S_CLEAR:  if (clr_addr == FB_LAST) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Out-of-range line pixels still take a cycle, they just never reach the RAM.
  always_comb begin
    fifo_pop = 1'b0;
    fb_we    = 1'b0;
    fb_waddr = '0;
    fb_wdata = cmd_color;
    case (state)
      S_IDLE, S_WAITB: fifo_pop = !fifo_empty;
      S_LINE: begin
        fb_we    = in_range;
        fb_waddr = line_addr;
      end
      S_CLEAR: begin
        fb_we    = 1'b1;
        fb_waddr = clr_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_clear <= 1'b0;
      cmd_color <= '0;
      cmd_y     <= '0;
      x         <= '0;
      xe        <= '0;
      clr_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: if (!fifo_empty) begin
          cmd_clear <= fifo_dout[CMD_CLEAR_BIT];
          cmd_color <= fifo_dout[CMD_COLOR_HI:CMD_COLOR_LO];
          cmd_y     <= fifo_dout[CMD_Y_HI:0];
        end
        S_DECODE: clr_addr <= '0;
        S_WAITB: if (!fifo_empty) begin
          x  <= span[15:8];
          xe <= span[7:0];
        end
        S_LINE:  if (x != xe) x <= x + 8'd1;
        S_CLEAR: clr_addr <= clr_addr + 1'b1;
        default: ;
      endcase
    end
  end

  pixel_t fb [FB_SIZE];

  always_ff @(posedge clk) begin
    if (fb_we) fb[fb_waddr] <= fb_wdata;
  end

  logic [9:0]       hcount, vcount;
  logic             visible, hsync_raw, vsync_raw;
  logic [FB_AW-1:0] rd_addr;
  pixel_t           rd_data;
  logic             vis_d, hs_d, vs_d;

  draw_unit_vga_timing u_vga (
    .clk       (clk),
    .rst_n     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .visible   (visible),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  assign rd_addr = visible ? FB_AW'(int'(vcount >> 2) * FB_W + int'(hcount >> 2)) : '0;

  always_ff @(posedge clk) begin
    rd_data <= fb[rd_addr];
  end

  // Syncs and visible flag ride alongside the RAM read so all outputs stay aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vis_d     <= 1'b0;
      hs_d      <= 1'b1;
      vs_d      <= 1'b1;
      bus.color <= '0;
      bus.hsync <= 1'b1;
      bus.vsync <= 1'b1;
    end else begin
      vis_d     <= visible;
      hs_d      <= hsync_raw;
      vs_d      <= vsync_raw;
      bus.color <= vis_d ? rd_data : '0;
      bus.hsync <= hs_d;
      bus.vsync <= vs_d;
    end
  end
endmodule

// File: tb/tb_draw_unit.sv
// Randomized self-checking bench for draw_unit against a pixel-level frame
// buffer model and an arithmetic VGA timing model.
module tb_draw_unit;
  import draw_unit_pkg::*;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  draw_unit_if bus();

  draw_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int     n_tests  = 0;
  int     n_fail   = 0;
  int     k        = 0;
  int     wr_count = 0;
  logic [2:0] model [N];

  always @(posedge clk) begin
    k <= reset ? k + 1 : 0;
    if (dut.fb_we) wr_count <= wr_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    int t = 0;
    while (bus.full === 1'b1 && t < 25000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 25000) begin
      check("push_timeout", 1, 0);
      return;
    end
    bus.we     = 1'b1;
    bus.dataIn = w;
    @(posedge clk); #1;
    bus.we     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    @(negedge clk);
    while (!(dut.state == S_IDLE && dut.fifo_empty) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("idle_reached", 32'(t < budget), 1);
  endtask

  function automatic logic [15:0] line_word(input int y, input int c);
    logic [15:0] w;
    w        = '0;
    w[14:10] = 5'($urandom);
    w[9:7]   = c[2:0];
    w[6:0]   = y[6:0];
    return w;
  endfunction

  // Reference rule: paint x=min..max on row y, skipping pixels off the buffer.
  task automatic model_line(input int y, input int c, input int x0, input int x1, inout int cnt);
    int lo = (x0 < x1) ? x0 : x1;
    int hi = (x0 < x1) ? x1 : x0;
    for (int xx = lo; xx <= hi; xx++) begin
      if (xx < W && y < H) begin
        model[y * W + xx] = c[2:0];
        cnt++;
      end
    end
  endtask

  task automatic model_fill(input int c);
    for (int a = 0; a < N; a++) model[a] = c[2:0];
  endtask

  task automatic compare_fb(input string tag);
    int bad = 0;
    for (int a = 0; a < N; a++) if (dut.fb[a] !== model[a]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic measure_hsync();
    int t = 0;
    int t_fall1, t_rise, t_fall2;
    while (bus.hsync !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
    t_fall1 = t;
    while (bus.hsync !== 1'b1 && t < 4000) begin @(negedge clk); t++; end
    t_rise = t;
    while (bus.hsync !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
    t_fall2 = t;
    check("hsync_low_clks", t_rise - t_fall1, 192);
    check("hsync_period_clks", t_fall2 - t_fall1, 1600);
    check("vsync_high_early", bus.vsync, 1);
  endtask

  // Output after posedge k shows pixel p = (k-2)/2 of the raster.
  task automatic vga_check(input int cycles);
    int p, h, v;
    logic [2:0] ec;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (i % 5 == 0) begin
        p  = (k - 2) / 2;
        h  = p % 800;
        v  = (p / 800) % 525;
        ec = (h < 640 && v < 480) ? model[(v / 4) * W + h / 4] : 3'd0;
        check("vga_color", bus.color, ec);
        check("vga_hsync", bus.hsync, (h >= 656 && h < 752) ? 0 : 1);
        check("vga_vsync", bus.vsync, (v >= 490 && v < 492) ? 0 : 1);
      end
    end
  endtask

  int w0;
  int exp_wr;
  logic [15:0] words [16];
  int ry [48], rc [48], rx0 [48], rx1 [48];

  initial begin
    bus.we     = 1'b0;
    bus.dataIn = '0;
    repeat (4) @(negedge clk);
    check("rst_full", bus.full, 0);
    check("rst_hsync", bus.hsync, 1);
    check("rst_vsync", bus.vsync, 1);
    check("rst_color", bus.color, 0);
    check("rst_state_idle", 32'(dut.state == S_IDLE), 1);
    reset = 1'b1;

    measure_hsync();

    w0 = wr_count;
    push(16'h8000);
    wait_idle(25000);
    model_fill(0);
    check("clear0_writes", wr_count - w0, 19200);
    compare_fb("clear0_fb");

    w0 = wr_count; exp_wr = 0;
    push(16'h0085);
    push(16'h000A);
    wait_idle(1000);
    model_line(5, 1, 0, 10, exp_wr);
    check("line_writes", wr_count - w0, 11);
    check("line_x0", dut.fb[5 * W + 0], 1);
    check("line_x10", dut.fb[5 * W + 10], 1);
    check("line_x11", dut.fb[5 * W + 11], 0);
    compare_fb("line_fb");

    w0 = wr_count; exp_wr = 0;
    push(16'h0383);
    push(16'h1405);
    wait_idle(1000);
    model_line(3, 7, 20, 5, exp_wr);
    check("rev_writes", wr_count - w0, 16);
    check("rev_x5", dut.fb[3 * W + 5], 7);
    check("rev_x20", dut.fb[3 * W + 20], 7);
    check("rev_x4", dut.fb[3 * W + 4], 0);
    check("rev_x21", dut.fb[3 * W + 21], 0);
    compare_fb("rev_fb");

    w0 = wr_count; exp_wr = 0;
    push(line_word(125, 4)); push({8'd0, 8'd10});
    push(line_word(7, 6));   push({8'd200, 8'd150});
    push(line_word(8, 5));   push({8'd3, 8'd3});
    wait_idle(2000);
    model_line(125, 4, 0, 10, exp_wr);
    model_line(7, 6, 200, 150, exp_wr);
    model_line(8, 5, 3, 3, exp_wr);
    check("oor_writes", wr_count - w0, exp_wr);
    compare_fb("oor_fb");

    w0 = wr_count; exp_wr = 0;
    for (int i = 0; i < 48; i++) begin
      ry[i]  = $urandom_range(0, 127);
      rc[i]  = $urandom_range(0, 7);
      rx0[i] = $urandom_range(0, 255);
      rx1[i] = $urandom_range(0, 255);
    end
    for (int i = 0; i < 8; i++) begin
      words[2 * i]     = line_word(ry[i], rc[i]);
      words[2 * i + 1] = {rx0[i][7:0], rx1[i][7:0]};
    end
    push(line_word(9, 2));
    push({8'd0, 8'd159});
    model_line(9, 2, 0, 159, exp_wr);
    repeat (5) @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      push(words[j]);
      check($sformatf("full_after_%0d", j + 1), bus.full, (j == 15) ? 1 : 0);
    end
    bus.we     = 1'b1;
    bus.dataIn = 16'h0380;
    repeat (20) begin @(posedge clk); #1; end
    bus.we     = 1'b0;
    check("full_held", bus.full, 1);
    for (int i = 8; i < 48; i++) begin
      push(line_word(ry[i], rc[i]));
      push({rx0[i][7:0], rx1[i][7:0]});
    end
    for (int i = 0; i < 48; i++) model_line(ry[i], rc[i], rx0[i], rx1[i], exp_wr);
    wait_idle(40000);
    check("rand_writes", wr_count - w0, exp_wr);
    compare_fb("rand_fb");

    w0 = wr_count;
    push(16'hFFFF);
    wait_idle(25000);
    model_fill(7);
    check("clear7_writes", wr_count - w0, 19200);
    compare_fb("clear7_fb");

    vga_check(3200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(20 * 150000);
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end
endmodule
